// File: rtl/sccomp_run_ctrl_if.sv
// sccomp_run_ctrl_if: host command handshake (valid/ready/op) between a host or bench and the run-control sequencer
interface sccomp_run_ctrl_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  modport master (output cmd_valid, output cmd_op, input cmd_ready);
  modport slave (input cmd_valid, input cmd_op, output cmd_ready);
endinterface

// File: rtl/sccomp_run_ctrl.sv
// sccomp_run_ctrl: sccomp run-control sequencer gating cpu_en with run/halt/step/clear, breakpoint and timeout halts; SCCOMP_EBREAK_HALT_EN adds halt-on-ebreak
module sccomp_run_ctrl #(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 3000
) (
  input  logic              clk,
  input  logic              rst,
  sccomp_run_ctrl_if.slave  cmd,
  input  logic              bp_en,
  input  logic [31:0]       bp_addr,
  input  logic [31:0]       pc,
  input  logic [31:0]       instr,
  output logic              cpu_en,
  output logic [1:0]        state,
  output logic [2:0]        halt_cause,
  output logic [CNT_W-1:0]  instr_cnt,
  output logic              step_done
);
  typedef enum logic [1:0] {IDLE, RUN, STEP, HALTED} state_t;
  localparam logic [1:0] OP_RUN = 2'd0, OP_HALT = 2'd1, OP_STEP = 2'd2, OP_CLR = 2'd3;
  localparam logic [31:0] EBREAK = 32'h0010_0073;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);
`ifdef SCCOMP_EBREAK_HALT_EN
  localparam bit EB_EN = 1'b1;
`else
  localparam bit EB_EN = 1'b0;
`endif
  state_t state_q;
  logic [2:0] cause_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic done_q, skip_q;
  logic eb_instr, bp_hit, eb_hit, acc, clr, tmo, halt_req;
  assign eb_instr = instr == EBREAK;
  assign bp_hit = bp_en && pc == bp_addr && !skip_q;
  assign eb_hit = EB_EN && state_q == RUN && eb_instr && !skip_q;
  assign cpu_en = !rst && ((state_q == RUN && !bp_hit && !eb_hit) || state_q == STEP);
  assign cmd.cmd_ready = state_q != STEP;
  assign acc = cmd.cmd_valid && cmd.cmd_ready;
  assign clr = acc && cmd.cmd_op == OP_CLR;
  assign cnt_d = clr ? '0 : (cpu_en && cnt_q != '1) ? cnt_q + CNT_W'(1) : cnt_q;
  assign tmo = TIMEOUT != 0 && state_q == RUN && cpu_en && !clr && cnt_q == TO_LAST;
  assign halt_req = bp_hit || eb_hit || tmo || (acc && cmd.cmd_op == OP_HALT);
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cause_q <= '0;
      cnt_q <= '0;
      done_q <= 1'b0;
      skip_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      done_q <= state_q == STEP;
      if (cpu_en) skip_q <= 1'b0;
      case (state_q)
        IDLE, HALTED: if (acc && (cmd.cmd_op == OP_RUN || cmd.cmd_op == OP_STEP)) begin
          state_q <= cmd.cmd_op == OP_RUN ? RUN : STEP;
          cause_q <= '0;
          skip_q <= cmd.cmd_op == OP_RUN && (pc == bp_addr || (EB_EN && eb_instr));
        end
        RUN: if (halt_req) begin
          state_q <= HALTED;
          cause_q <= bp_hit ? 3'd3 : eb_hit ? 3'd5 : tmo ? 3'd4 : 3'd1;
        end
        default: begin
          state_q <= HALTED;
          cause_q <= 3'd2;
        end
      endcase
    end
  end
  assign state = state_q;
  assign halt_cause = cause_q;
  assign instr_cnt = cnt_q;
  assign step_done = done_q;
endmodule

// File: tb/tb_sccomp_run_ctrl.sv
// tb_sccomp_run_ctrl: randomized and directed bench for sccomp_run_ctrl against a rule-level reference model
module tb_sccomp_run_ctrl;
  localparam int TIMEOUT = 3000;
  localparam logic [31:0] EBRK = 32'h0010_0073;
  localparam logic [63:0] CNT_MAX = 64'hFFFF_FFFF;
`ifdef SCCOMP_EBREAK_HALT_EN
  localparam bit EB_EN = 1'b1;
`else
  localparam bit EB_EN = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic bp_en = 1'b0;
  logic [31:0] bp_addr = '0;
  logic [31:0] pc = '0;
  logic [31:0] instr;
  logic cpu_en, step_done;
  logic [1:0] state;
  logic [2:0] halt_cause;
  logic [31:0] instr_cnt;
  logic eb_on = 1'b0;
  logic [31:0] eb_pc = '0;
  bit jumpy = 1'b0;
  int checks = 0, errors = 0, en_cycles = 0, pulses = 0, e0, p0;
  int m_st, m_cause;
  logic [63:0] m_cnt;
  bit m_skip, m_done, m_valid;
  bit bp, eb, exec, acc, clr, tmo;
  int causes[4];
  sccomp_run_ctrl_if cif();
  always #5 clk = ~clk;
  assign instr = (eb_on && pc == eb_pc) ? EBRK : 32'h0000_0013;
  sccomp_run_ctrl #(.CNT_W(32), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .cmd(cif), .bp_en(bp_en), .bp_addr(bp_addr), .pc(pc), .instr(instr),
    .cpu_en(cpu_en), .state(state), .halt_cause(halt_cause), .instr_cnt(instr_cnt), .step_done(step_done)
  );
  always @(posedge clk)
    if (rst) pc <= '0;
    else if (cpu_en) pc <= (jumpy && $urandom_range(3, 0) == 0) ? 32'($urandom_range(15, 0)) << 2 : pc + 32'd4;
  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, exp, $time);
    end
  endtask
  initial forever begin
    @(negedge clk);
    #2;
    bp = bp_en && pc == bp_addr && !m_skip;
    eb = EB_EN && m_st == 1 && instr == EBRK && !m_skip;
    exec = !rst && ((m_st == 1 && !bp && !eb) || m_st == 2);
    if (m_valid) begin
      chk("cpu_en", cpu_en, exec);
      chk("cmd_ready", cif.cmd_ready, m_st != 2);
      chk("state", state, m_st);
      chk("halt_cause", halt_cause, m_cause);
      chk("instr_cnt", instr_cnt, m_cnt);
      chk("step_done", step_done, m_done);
    end
    if (cpu_en === 1'b1) en_cycles++;
    if (step_done === 1'b1) pulses++;
    if (rst) begin
      m_st = 0; m_cause = 0; m_cnt = 0; m_skip = 0; m_done = 0; m_valid = 1;
    end else begin
      acc = cif.cmd_valid && m_st != 2;
      clr = acc && cif.cmd_op == 2'd3;
      tmo = m_st == 1 && exec && !clr && TIMEOUT != 0 && m_cnt == 64'(TIMEOUT - 1);
      causes = '{bp ? 3 : 0, eb ? 5 : 0, tmo ? 4 : 0, (acc && cif.cmd_op == 2'd1) ? 1 : 0};
      m_done = m_st == 2;
      if (clr) m_cnt = 0;
      else if (exec && m_cnt != CNT_MAX) m_cnt = m_cnt + 1;
      if (exec) m_skip = 0;
      if (m_st == 2) begin
        m_st = 3; m_cause = 2;
      end else if (m_st == 1) begin
        foreach (causes[i]) if (m_st == 1 && causes[i] != 0) begin
          m_st = 3; m_cause = causes[i];
        end
      end else if (acc && cif.cmd_op == 2'd0) begin
        m_st = 1; m_cause = 0;
        m_skip = pc == bp_addr || (EB_EN && instr == EBRK);
      end else if (acc && cif.cmd_op == 2'd2) begin
        m_st = 2; m_cause = 0;
      end
    end
  end
  task automatic tick();
    @(negedge clk);
    #1;
  endtask
  task automatic send(input logic [1:0] op);
    cif.cmd_valid = 1'b1;
    cif.cmd_op = op;
    tick();
    cif.cmd_valid = 1'b0;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask
  task automatic wait_state(input logic [1:0] s, input int maxc);
    int n = 0;
    while (state !== s && n < maxc) begin
      tick();
      n++;
    end
    chk("wait_state", state, s);
  endtask
  initial begin
    cif.cmd_valid = 1'b0;
    cif.cmd_op = 2'd0;
    do_reset();
    chk("rst_state", state, 0);
    chk("rst_cpu_en", cpu_en, 0);
    chk("rst_cnt", instr_cnt, 0);
    chk("rst_cause", halt_cause, 0);
    chk("rst_ready", cif.cmd_ready, 1);
    e0 = en_cycles;
    send(2'd0);
    wait_state(2'd3, TIMEOUT + 100);
    chk("to_cause", halt_cause, 4);
    chk("to_cnt", instr_cnt, TIMEOUT);
    chk("to_cpu_en", cpu_en, 0);
    chk("to_en_cycles", en_cycles - e0, TIMEOUT);
    do_reset();
    bp_en = 1'b1;
    bp_addr = 32'h10;
    send(2'd0);
    wait_state(2'd3, 20);
    chk("bp_cause", halt_cause, 3);
    chk("bp_cnt", instr_cnt, 4);
    chk("bp_pc", pc, 32'h10);
    chk("bp_cpu_en", cpu_en, 0);
    send(2'd0);
    chk("resume_cpu_en", cpu_en, 1);
    tick();
    chk("resume_cnt", instr_cnt, 5);
    chk("resume_pc", pc, 32'h14);
    send(2'd1);
    chk("host_state", state, 3);
    chk("host_cause", halt_cause, 1);
    chk("host_cnt", instr_cnt, 6);
    p0 = pulses;
    for (int i = 0; i < 3; i++) begin
      send(2'd2);
      chk("step_state", state, 2);
      chk("step_ready", cif.cmd_ready, 0);
      chk("step_cpu_en", cpu_en, 1);
      tick();
      chk("step_done", step_done, 1);
      chk("step_cause", halt_cause, 2);
    end
    tick();
    chk("step_pulses", pulses - p0, 3);
    chk("step_cnt", instr_cnt, 9);
    do_reset();
    send(2'd0);
    for (int n = 0; n < 20 && pc !== 32'h10; n++) tick();
    chk("bphalt_cpu_en", cpu_en, 0);
    send(2'd1);
    chk("bphalt_cause", halt_cause, 3);
    chk("bphalt_cnt", instr_cnt, 4);
    bp_en = 1'b0;
    send(2'd0);
    tick();
    tick();
    tick();
    send(2'd3);
    chk("clr_cnt", instr_cnt, 0);
    chk("clr_state", state, 1);
    send(2'd1);
    chk("clr_halt_cnt", instr_cnt, 1);
    do_reset();
    eb_on = 1'b1;
    eb_pc = 32'h8;
    send(2'd0);
    if (EB_EN) begin
      wait_state(2'd3, 20);
      chk("eb_cause", halt_cause, 5);
      chk("eb_cnt", instr_cnt, 2);
      chk("eb_pc", pc, 32'h8);
      send(2'd0);
      tick();
      chk("eb_resume_cnt", instr_cnt, 3);
      chk("eb_resume_state", state, 1);
    end else begin
      tick();
      tick();
      tick();
      tick();
      chk("eb_pass_state", state, 1);
      chk("eb_pass_cnt", instr_cnt, 4);
    end
    send(2'd1);
    eb_on = 1'b0;
    send(2'd0);
    for (int i = 0; i < 5; i++) tick();
    rst = 1'b1;
    #1;
    chk("midrst_cpu_en", cpu_en, 0);
    tick();
    rst = 1'b0;
    chk("midrst_state", state, 0);
    chk("midrst_cnt", instr_cnt, 0);
    jumpy = 1'b1;
    for (int i = 0; i < 6000; i++) begin
      rst = $urandom_range(199, 0) == 0;
      cif.cmd_valid = $urandom_range(3, 0) == 0;
      cif.cmd_op = 2'($urandom_range(3, 0));
      bp_en = $urandom_range(3, 0) != 0;
      eb_on = $urandom_range(1, 0) == 1;
      if ($urandom_range(49, 0) == 0) bp_addr = 32'($urandom_range(15, 0)) << 2;
      if ($urandom_range(49, 0) == 0) eb_pc = 32'($urandom_range(15, 0)) << 2;
      tick();
    end
    rst = 1'b0;
    cif.cmd_valid = 1'b0;
    tick();
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
